// File: rtl/core2axi4l_pipelined_if.sv
// rtl/core2axi4l_pipelined_if.sv - AXI4-Lite bus bundle between the core bridge and the fabric
interface core2axi4l_pipelined_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [AddrWidth-1:0]   awaddr;
    logic [2:0]             awprot;

    logic                   wvalid;
    logic                   wready;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] wstrb;

    logic                   bvalid;
    logic                   bready;
    logic [1:0]             bresp;

    logic                   arvalid;
    logic                   arready;
    logic [AddrWidth-1:0]   araddr;
    logic [2:0]             arprot;

    logic                   rvalid;
    logic                   rready;
    logic [DataWidth-1:0]   rdata;
    logic [1:0]             rresp;

    modport master (
        output awvalid, awaddr, awprot,
        output wvalid, wdata, wstrb,
        output bready,
        output arvalid, araddr, arprot,
        output rready,
        input  awready, wready, bvalid, bresp,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot,
        input  wvalid, wdata, wstrb,
        input  bready,
        input  arvalid, araddr, arprot,
        input  rready,
        output awready, wready, bvalid, bresp,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/core2axi4l_pipelined.sv
// rtl/core2axi4l_pipelined.sv - Ibex req/gnt port to AXI4-Lite master with multiple outstanding transactions
module core2axi4l_pipelined #(
    parameter int   AddrWidth      = 32,
    parameter int   DataWidth      = 32,
    parameter int   MaxOutstanding = 4,
    parameter logic InstrPort      = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   core_req,
    output logic                   core_gnt,
    input  logic                   core_we,
    input  logic [DataWidth/8-1:0] core_be,
    input  logic [AddrWidth-1:0]   core_addr,
    input  logic [DataWidth-1:0]   core_wdata,
    output logic                   core_rvalid,
    output logic [DataWidth-1:0]   core_rdata,
    output logic                   core_err,

    core2axi4l_pipelined_if.master axi
);
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

    // Request channel registers: each holds its payload stable until its own handshake.
    logic                   ar_valid_q;
    logic [AddrWidth-1:0]   ar_addr_q;
    logic                   aw_valid_q;
    logic [AddrWidth-1:0]   aw_addr_q;
    logic                   w_valid_q;
    logic [DataWidth-1:0]   w_data_q;
    logic [DataWidth/8-1:0] w_strb_q;

    // Order FIFO of transaction kinds (1 = write); occupancy is the outstanding count.
    logic [CntW-1:0]           cnt;
    logic [MaxOutstanding-1:0] order_we;
    logic [PtrW-1:0]           wr_ptr;
    logic [PtrW-1:0]           rd_ptr;

    logic fifo_empty;
    logic head_we;
    logic slot_free;
    logic rd_done;
    logic wr_done;
    logic unused_resp;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    assign fifo_empty = (cnt == '0);
    assign head_we    = order_we[rd_ptr];

    // A new request may only load a channel register that is currently empty.
    assign slot_free = core_we ? (!aw_valid_q && !w_valid_q) : !ar_valid_q;
    assign core_gnt  = core_req && !rst && (cnt < MaxCnt) && slot_free;

    // Only the channel matching the oldest outstanding transaction is allowed to respond.
    assign axi.rready = !rst && !fifo_empty && !head_we;
    assign axi.bready = !rst && !fifo_empty && head_we;

    assign rd_done     = axi.rvalid && axi.rready;
    assign wr_done     = axi.bvalid && axi.bready;
    assign core_rvalid = rd_done || wr_done;
    assign core_rdata  = axi.rdata;
    assign core_err    = (rd_done && axi.rresp[1]) || (wr_done && axi.bresp[1]);
    assign unused_resp = axi.rresp[0] ^ axi.bresp[0];

    assign axi.arvalid = ar_valid_q;
    assign axi.araddr  = ar_addr_q;
    assign axi.arprot  = InstrPort ? 3'b100 : 3'b000;
    assign axi.awvalid = aw_valid_q;
    assign axi.awaddr  = aw_addr_q;
    assign axi.awprot  = InstrPort ? 3'b100 : 3'b000;
    assign axi.wvalid  = w_valid_q;
    assign axi.wdata   = w_data_q;
    assign axi.wstrb   = w_strb_q;

    // Load AR/AW/W on grant; each valid drops independently on its own handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            aw_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            w_valid_q  <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
        end else begin
            if (core_gnt && !core_we) begin
                ar_valid_q <= 1'b1;
                ar_addr_q  <= core_addr;
            end else if (axi.arready) begin
                ar_valid_q <= 1'b0;
            end

            if (core_gnt && core_we) begin
                aw_valid_q <= 1'b1;
                aw_addr_q  <= core_addr;
                w_valid_q  <= 1'b1;
                w_data_q   <= core_wdata;
                w_strb_q   <= core_be;
            end else begin
                if (axi.awready) begin
                    aw_valid_q <= 1'b0;
                end
                if (axi.wready) begin
                    w_valid_q <= 1'b0;
                end
            end
        end
    end

    // Track outstanding transactions in grant order; push on grant, pop on core response.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            order_we <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (core_gnt) begin
                order_we[wr_ptr] <= core_we;
                wr_ptr           <= ptr_next(wr_ptr);
            end
            if (core_rvalid) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({core_gnt, core_rvalid})
                2'b10:   cnt <= cnt + CntW'(1);
                2'b01:   cnt <= cnt - CntW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule
